// File: rtl/memory_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage_if
// Description : Data-memory request/response bus between the memory pipeline
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : Execute->memory pipeline register, data-memory handshake FSM,
//               store lane alignment and load byte/half reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage #(
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [31:0]                  alu_result_e_i,
  input  logic [31:0]                  write_data_e_i,
  input  logic [31:0]                  pc_target_e_i,
  input  logic [31:0]                  pc_plus4_e_i,
  input  logic [31:0]                  imm_ext_e_i,
  input  logic [4:0]                   rd_e_i,
  input  logic [2:0]                   result_src_e_i,
  input  logic                         reg_write_e_i,
  input  logic                         mem_read_e_i,
  input  logic                         mem_write_e_i,
  input  logic [2:0]                   width_e_i,
  input  logic                         stall_m_i,
  memory_access_stage_if.master        dmem,
  output logic [31:0]                  alu_result_m_o,
  output logic [31:0]                  reduced_data_m_o,
  output logic [31:0]                  pc_target_m_o,
  output logic [31:0]                  pc_plus4_m_o,
  output logic [31:0]                  imm_ext_m_o,
  output logic [4:0]                   rd_m_o,
  output logic [2:0]                   result_src_m_o,
  output logic                         reg_write_m_o,
  output logic                         mem_busy_o,
  output logic                         misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RESP = 2'd1,
    S_DONE      = 2'd2
  } state_e;

  // M pipeline register contents
  logic [31:0] alu_result_q;
  logic [31:0] write_data_q;
  logic [31:0] pc_target_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] imm_ext_q;
  logic [4:0]  rd_q;
  logic [2:0]  result_src_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [2:0]  width_q;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_mem;
  logic        is_half;
  logic        is_word;
  logic        op_m;
  logic [1:0]  a_lo;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign a_lo    = alu_result_q[1:0];
  assign is_mem  = mem_read_q | mem_write_q;
  // width[1:0]: 00 byte, 01 half, 10 word; width[2] selects zero-extension
  assign is_half = (width_q[1:0] == 2'b01);
  assign is_word = (width_q[1:0] == 2'b10);
  assign misaligned_o = is_mem & ((is_half & a_lo[0]) | (is_word & (a_lo != 2'b00)));
  assign op_m         = is_mem & ~misaligned_o;

  // Execute->memory register; a stall freezes the whole instruction in M
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_target_q  <= '0;
      pc_plus4_q   <= RESET_PC_PLUS4;
      imm_ext_q    <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      width_q      <= '0;
    end else if (!stall_m_i) begin
      alu_result_q <= alu_result_e_i;
      write_data_q <= write_data_e_i;
      pc_target_q  <= pc_target_e_i;
      pc_plus4_q   <= pc_plus4_e_i;
      imm_ext_q    <= imm_ext_e_i;
      rd_q         <= rd_e_i;
      result_src_q <= result_src_e_i;
      reg_write_q  <= reg_write_e_i;
      mem_read_q   <= mem_read_e_i;
      mem_write_q  <= mem_write_e_i;
      width_q      <= width_e_i;
    end
  end

  // Handshake state and captured load word; reset abandons any transaction
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: a new instruction entering M always restarts in IDLE
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    if (!stall_m_i) begin
      state_d = S_IDLE;
      rdata_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_m && dmem.gnt) begin
            state_d = mem_write_q ? S_DONE : S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (dmem.rvalid) begin
            rdata_d = dmem.rdata;
            state_d = S_DONE;
          end
        end
        // DONE holds until the next instruction loads, so an external stall
        // cannot cause the same access to be issued twice
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Request/busy outputs and store lane alignment
  always_comb begin
    dmem.req   = (state_q == S_IDLE) & op_m;
    mem_busy_o = op_m & (state_q != S_DONE);
    dmem.we    = mem_write_q;
    dmem.addr  = {alu_result_q[31:2], 2'b00};
    dmem.be    = 4'b1111;
    dmem.wdata = write_data_q;
    if (mem_write_q) begin
      case (width_q[1:0])
        2'b00: begin
          dmem.be    = 4'b0001 << a_lo;
          dmem.wdata = {4{write_data_q[7:0]}};
        end
        2'b01: begin
          dmem.be    = a_lo[1] ? 4'b1100 : 4'b0011;
          dmem.wdata = {2{write_data_q[15:0]}};
        end
        default: begin
          dmem.be    = 4'b1111;
          dmem.wdata = write_data_q;
        end
      endcase
    end
  end

  // Load reduction: pick the addressed byte/half and sign or zero extend
  always_comb begin
    case (a_lo)
      2'd0:    sel_byte = rdata_q[7:0];
      2'd1:    sel_byte = rdata_q[15:8];
      2'd2:    sel_byte = rdata_q[23:16];
      default: sel_byte = rdata_q[31:24];
    endcase
    sel_half         = a_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
    reduced_data_m_o = '0;
    if (mem_read_q) begin
      case (width_q[1:0])
        2'b00:   reduced_data_m_o = {{24{~width_q[2] & sel_byte[7]}}, sel_byte};
        2'b01:   reduced_data_m_o = {{16{~width_q[2] & sel_half[15]}}, sel_half};
        default: reduced_data_m_o = rdata_q;
      endcase
    end
  end

  assign alu_result_m_o = alu_result_q;
  assign pc_target_m_o  = pc_target_q;
  assign pc_plus4_m_o   = pc_plus4_q;
  assign imm_ext_m_o    = imm_ext_q;
  assign rd_m_o         = rd_q;
  assign result_src_m_o = result_src_q;
  // A misaligned access is suppressed entirely, including its writeback
  assign reg_write_m_o  = reg_write_q & ~misaligned_o;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_stage
// Description : Self-checking bench for memory_access_stage: directed vector
//               table, reset corner cases and randomized ops against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] alu_result_e_i, write_data_e_i, pc_target_e_i, pc_plus4_e_i, imm_ext_e_i;
  logic [4:0]  rd_e_i;
  logic [2:0]  result_src_e_i;
  logic        reg_write_e_i, mem_read_e_i, mem_write_e_i;
  logic [2:0]  width_e_i;
  logic        stall_m_i;
  logic        ext_stall;
  logic [31:0] alu_result_m_o, reduced_data_m_o, pc_target_m_o, pc_plus4_m_o, imm_ext_m_o;
  logic [4:0]  rd_m_o;
  logic [2:0]  result_src_m_o;
  logic        reg_write_m_o, mem_busy_o, misaligned_o;

  int    n_cmp = 0;
  int    n_fail = 0;
  string cur_tag = "init";

  memory_access_stage_if dmem();

  memory_access_stage #(.RESET_PC_PLUS4(32'h0000_0004)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .alu_result_e_i  (alu_result_e_i),
    .write_data_e_i  (write_data_e_i),
    .pc_target_e_i   (pc_target_e_i),
    .pc_plus4_e_i    (pc_plus4_e_i),
    .imm_ext_e_i     (imm_ext_e_i),
    .rd_e_i          (rd_e_i),
    .result_src_e_i  (result_src_e_i),
    .reg_write_e_i   (reg_write_e_i),
    .mem_read_e_i    (mem_read_e_i),
    .mem_write_e_i   (mem_write_e_i),
    .width_e_i       (width_e_i),
    .stall_m_i       (stall_m_i),
    .dmem            (dmem),
    .alu_result_m_o  (alu_result_m_o),
    .reduced_data_m_o(reduced_data_m_o),
    .pc_target_m_o   (pc_target_m_o),
    .pc_plus4_m_o    (pc_plus4_m_o),
    .imm_ext_m_o     (imm_ext_m_o),
    .rd_m_o          (rd_m_o),
    .result_src_m_o  (result_src_m_o),
    .reg_write_m_o   (reg_write_m_o),
    .mem_busy_o      (mem_busy_o),
    .misaligned_o    (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  // Hazard unit: stall whenever the stage is busy, plus any external hold
  assign stall_m_i = mem_busy_o | ext_stall;

  // Stall contract: the M register must never advance while busy
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      n_cmp++;
      assert (!(mem_busy_o && !stall_m_i)) else begin
        n_fail++;
        $display("FAIL stall_contract: busy=%0b stall=%0b required stall=1", mem_busy_o, stall_m_i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: actual=%h required=%h", cur_tag, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model, written from the architectural rules
  function automatic void model(input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input logic [2:0] width,
                                input bit ld, input bit st,
                                output bit mis, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] red);
    int unsigned a = addr % 4;
    int unsigned w = width % 4;
    bit          uns = (width >= 4);
    logic [31:0] b, h;
    mis = (ld || st) && ((w == 1 && (a % 2) == 1) || (w == 2 && a != 0));
    be = 4'hF;
    wdata = rs2;
    if (st && w == 0) begin
      be = 4'(1 << a);
      wdata = (rs2 & 32'hFF) * 32'h0101_0101;
    end else if (st && w == 1) begin
      be = (a >= 2) ? 4'hC : 4'h3;
      wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
    end
    red = 0;
    if (ld) begin
      if (w == 0) begin
        b = (rdata >> (8 * a)) & 32'hFF;
        red = (!uns && b >= 128) ? b + 32'hFFFF_FF00 : b;
      end else if (w == 1) begin
        h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
        red = (!uns && h >= 32768) ? h + 32'hFFFF_0000 : h;
      end else begin
        red = rdata;
      end
    end
  endfunction

  // Load one instruction into M, run the memory handshake with a grant after
  // g cycles and rvalid r cycles after the grant cycle, hold an external
  // stall for 'hold' extra cycles, then check the outcome.
  task automatic do_op(input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                       input logic [2:0] width, input bit ld, input bit st, input bit rw,
                       input logic [4:0] rd, input int g, input int r, input int hold,
                       input bit e_mis, input logic [3:0] e_be, input logic [31:0] e_wdata,
                       input logic [31:0] e_red);
    logic [31:0] pct = $urandom, pp4 = $urandom, imm = $urandom;
    logic [2:0]  rsrc = 3'($urandom_range(0, 7));
    bit          op = (ld || st) && !e_mis;
    int          busy_exp = !op ? 0 : (st ? g + 1 : g + 2 + r);
    int          req_exp = op ? g + 1 : 0;
    int          req_cnt = 0, busy_cnt = 0;
    alu_result_e_i = addr;  write_data_e_i = rs2; pc_target_e_i = pct;
    pc_plus4_e_i = pp4;     imm_ext_e_i = imm;    rd_e_i = rd;
    result_src_e_i = rsrc;  reg_write_e_i = rw;   mem_read_e_i = ld;
    mem_write_e_i = st;     width_e_i = width;    ext_stall = 1'b0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = $urandom;
    tick();
    // Scramble execute inputs: M must hold its instruction while stalled
    alu_result_e_i = $urandom; write_data_e_i = $urandom; rd_e_i = 5'($urandom);
    mem_read_e_i = 1'b0; mem_write_e_i = 1'b0;
    ext_stall = 1'b1;
    for (int c = 0; c < busy_exp + hold; c++) begin
      dmem.gnt = op && (c == g);
      dmem.rvalid = op && ld && (c == g + 1 + r);
      dmem.rdata = dmem.rvalid ? rdata : $urandom;
      #1;
      req_cnt += int'(dmem.req);
      busy_cnt += int'(mem_busy_o);
      if (dmem.req) begin
        chk("addr", dmem.addr, {addr[31:2], 2'b00});
        chk("we", {31'b0, dmem.we}, {31'b0, st});
        chk("be", {28'b0, dmem.be}, {28'b0, e_be});
        if (st) chk("wdata", dmem.wdata, e_wdata);
      end
      if (c >= busy_exp) chk("red_hold", reduced_data_m_o, e_red);
      tick();
    end
    ext_stall = 1'b0; dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    #1;
    req_cnt += int'(dmem.req);
    busy_cnt += int'(mem_busy_o);
    chk("req_cycles", req_cnt, req_exp);
    chk("busy_cycles", busy_cnt, busy_exp);
    chk("busy_final", {31'b0, mem_busy_o}, 32'd0);
    chk("reduced", reduced_data_m_o, e_red);
    chk("misaligned", {31'b0, misaligned_o}, {31'b0, e_mis});
    chk("reg_write", {31'b0, reg_write_m_o}, {31'b0, rw && !e_mis});
    chk("alu_result", alu_result_m_o, addr);
    chk("rd", {27'b0, rd_m_o}, {27'b0, rd});
    chk("result_src", {29'b0, result_src_m_o}, {29'b0, rsrc});
    chk("pc_target", pc_target_m_o, pct);
    chk("pc_plus4", pc_plus4_m_o, pp4);
    chk("imm_ext", imm_ext_m_o, imm);
  endtask

  typedef struct {
    logic [31:0] addr, rs2, rdata;
    logic [2:0]  width;
    bit          ld, st, rw;
    logic [4:0]  rd;
    int          g, r, hold;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wdata, red;
  } vec_t;

  task automatic zero_e();
    alu_result_e_i = '0; write_data_e_i = '0; pc_target_e_i = '0; pc_plus4_e_i = '0;
    imm_ext_e_i = '0; rd_e_i = '0; result_src_e_i = '0; reg_write_e_i = 1'b0;
    mem_read_e_i = 1'b0; mem_write_e_i = 1'b0; width_e_i = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", {31'b0, dmem.req}, 32'd0);
    chk("rst_busy", {31'b0, mem_busy_o}, 32'd0);
    chk("rst_mis", {31'b0, misaligned_o}, 32'd0);
    chk("rst_reduced", reduced_data_m_o, 32'd0);
    chk("rst_alu", alu_result_m_o, 32'd0);
    chk("rst_pc_plus4", pc_plus4_m_o, 32'h0000_0004);
    chk("rst_reg_write", {31'b0, reg_write_m_o}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[13];
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wd, red, addr, rs2, rdat;
    logic [2:0]  w;
    bit          ld, st;

    tbl[0]  = '{32'h1003, 32'h0, 32'h80FF_1234, 3'b000, 1, 0, 1, 5'd1, 0, 0, 0, 0, 4'hF, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{32'h1003, 32'h0, 32'h80FF_1234, 3'b100, 1, 0, 1, 5'd2, 0, 0, 0, 0, 4'hF, 32'h0, 32'h0000_0080};
    tbl[2]  = '{32'h2002, 32'h1234_ABCD, 32'h0, 3'b001, 0, 1, 0, 5'd3, 3, 0, 0, 0, 4'hC, 32'hABCD_ABCD, 32'h0};
    tbl[3]  = '{32'h3001, 32'h0, 32'h1111_2222, 3'b010, 1, 0, 1, 5'd4, 0, 0, 0, 1, 4'hF, 32'h0, 32'h0};
    tbl[4]  = '{32'h4000, 32'h0, 32'hCAFE_F00D, 3'b010, 1, 0, 1, 5'd5, 1, 2, 3, 0, 4'hF, 32'h0, 32'hCAFE_F00D};
    tbl[5]  = '{32'h55, 32'h0, 32'h0, 3'b000, 0, 0, 1, 5'd7, 0, 0, 0, 0, 4'hF, 32'h0, 32'h0};
    tbl[6]  = '{32'h5002, 32'h0, 32'h8001_7FFF, 3'b001, 1, 0, 1, 5'd8, 0, 1, 0, 0, 4'hF, 32'h0, 32'hFFFF_8001};
    tbl[7]  = '{32'h5000, 32'h0, 32'h8001_F00F, 3'b101, 1, 0, 1, 5'd9, 2, 0, 1, 0, 4'hF, 32'h0, 32'h0000_F00F};
    tbl[8]  = '{32'h6001, 32'h0000_00A5, 32'h0, 3'b000, 0, 1, 0, 5'd10, 0, 0, 0, 0, 4'h2, 32'hA5A5_A5A5, 32'h0};
    tbl[9]  = '{32'h7000, 32'hDEAD_BEEF, 32'h0, 3'b010, 0, 1, 0, 5'd11, 2, 0, 2, 0, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[10] = '{32'h8001, 32'h1234_5678, 32'h0, 3'b001, 0, 1, 1, 5'd12, 0, 0, 0, 1, 4'hF, 32'h0, 32'h0};
    tbl[11] = '{32'h9001, 32'h0, 32'h1234_5678, 3'b000, 1, 0, 1, 5'd13, 0, 0, 0, 0, 4'hF, 32'h0, 32'h0000_0056};
    tbl[12] = '{32'hA000, 32'h0, 32'h8000_0001, 3'b010, 1, 0, 1, 5'd14, 0, 1, 0, 0, 4'hF, 32'h0, 32'h8000_0001};

    // Power-on reset
    reset_n_i = 1'b0; ext_stall = 1'b0; zero_e();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    tick(); tick();
    cur_tag = "por";
    chk_reset_outputs();
    reset_n_i = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_op(tbl[i].addr, tbl[i].rs2, tbl[i].rdata, tbl[i].width, tbl[i].ld, tbl[i].st,
            tbl[i].rw, tbl[i].rd, tbl[i].g, tbl[i].r, tbl[i].hold,
            tbl[i].mis, tbl[i].be, tbl[i].wdata, tbl[i].red);
    end

    // Reset while waiting for the load response
    cur_tag = "rst_mid";
    alu_result_e_i = 32'h100; mem_read_e_i = 1'b1; width_e_i = 3'b010; reg_write_e_i = 1'b1;
    ext_stall = 1'b0;
    tick();
    dmem.gnt = 1'b1;
    #1;
    chk("req_before", {31'b0, dmem.req}, 32'd1);
    tick();
    dmem.gnt = 1'b0;
    #1;
    chk("busy_wait", {31'b0, mem_busy_o}, 32'd1);
    zero_e();
    reset_n_i = 1'b0;
    #1;
    chk_reset_outputs();
    tick();
    reset_n_i = 1'b1;
    dmem.rvalid = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    #1;
    chk("busy_after", {31'b0, mem_busy_o}, 32'd0);
    tick();
    dmem.rvalid = 1'b0;
    #1;
    chk("late_rvalid", reduced_data_m_o, 32'd0);
    chk("req_after", {31'b0, dmem.req}, 32'd0);

    // Randomized ops checked against the reference model
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      int wsel = $urandom_range(0, (kind == 2) ? 2 : 4);
      cur_tag = $sformatf("rnd%0d", i);
      ld = (kind == 1);
      st = (kind == 2);
      case (wsel)
        0: w = 3'b000;
        1: w = 3'b001;
        2: w = 3'b010;
        3: w = 3'b100;
        default: w = 3'b101;
      endcase
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w[1:0] == 2'b01) addr[0] = 1'b0;
        if (w[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      rs2 = $urandom;
      rdat = $urandom;
      model(addr, rs2, rdat, w, ld, st, mis, be, wd, red);
      do_op(addr, rs2, rdat, w, ld, st, 1'($urandom), 5'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
            mis, be, wd, red);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
